sar_scan_adc: RTL and testbench

SAR_SCAN_ADC -- requirements
Module: sar_scan_adc

---
 rtl/sar_scan_adc.sv | 166 ++++++++++++++++
 tb/tb_sar_scan_adc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_adc.sv
// Multi-channel successive-approximation ADC sequencer driving an R2R DAC and an
// external comparator, with optional per-channel averaging and continuous scanning.
module sar_scan_adc #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 6250,
    parameter int NUM_CH        = 4,
    parameter int AVG_LOG2      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    continuous,
    input  logic                                    avg_en,
    input  logic                                    comp_in,
    output logic [WIDTH-1:0]                        dac_out,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic [WIDTH-1:0]                        result,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] result_ch,
    output logic                                    result_valid,
    output logic                                    scan_done,
    output logic                                    busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [WIDTH-1:0] MSB_CODE  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(WIDTH - 1);
    localparam logic [AVG_W-1:0] CONV_LAST = AVG_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, TRIAL, DONE} state_t;

    state_t           r_state;
    logic             r_sync1, r_sync2;
    logic [WIDTH-1:0] r_dac;
    logic [BIT_W-1:0] r_bit;
    logic [CNT_W-1:0] r_settle;
    logic [ACC_W-1:0] r_acc;
    logic             r_avg;
    logic [AVG_W-1:0] r_conv;
    logic [CH_W-1:0]  r_ch;
    logic [WIDTH-1:0] r_result;
    logic [CH_W-1:0]  r_result_ch;
    logic             r_valid;
    logic             r_scan_done;
    logic             r_busy;

    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_code;
    logic [ACC_W-1:0] w_avg_res;
    logic             w_last_settle;
    logic             w_last_conv;
    logic             w_last_ch;

    // Trial bit is kept when the comparator says Vin >= Vdac, cleared otherwise.
    assign w_bit_mask    = LSB_ONE << r_bit;
    assign w_code        = r_sync2 ? r_dac : (r_dac & ~w_bit_mask);
    assign w_avg_res     = r_avg ? (r_acc >> AVG_LOG2) : r_acc;
    assign w_last_settle = (r_settle == SETTLE_LAST);
    assign w_last_conv   = !r_avg || (r_conv == CONV_LAST);
    assign w_last_ch     = (r_ch == CH_LAST);

    // NOTE: every register here is state updated on the clock edge, so all
    // assignments are non-blocking; blocking ones would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_dac       <= '0;
            r_bit       <= '0;
            r_settle    <= '0;
            r_acc       <= '0;
            r_avg       <= 1'b0;
            r_conv      <= '0;
            r_ch        <= '0;
            r_result    <= '0;
            r_result_ch <= '0;
            r_valid     <= 1'b0;
            r_scan_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= comp_in;
            r_sync2     <= r_sync1;
            r_valid     <= 1'b0;
            r_scan_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_avg    <= avg_en && (AVG_LOG2 != 0);
                        r_ch     <= '0;
                        r_dac    <= MSB_CODE;
                        r_bit    <= BIT_TOP;
                        r_settle <= '0;
                        r_conv   <= '0;
                        r_acc    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= TRIAL;
                    end
                end
                TRIAL: begin
                    if (!w_last_settle) begin
                        r_settle <= r_settle + CNT_W'(1);
                    end else begin
                        r_settle <= '0;
                        if (r_bit != '0) begin
                            r_dac <= w_code | (w_bit_mask >> 1);
                            r_bit <= r_bit - BIT_W'(1);
                        end else begin
                            r_acc <= r_acc + ACC_W'(w_code);
                            if (w_last_conv) begin
                                r_dac   <= w_code;
                                r_state <= DONE;
                            end else begin
                                // Averaging: next conversion on the same channel, back to back.
                                r_conv <= r_conv + AVG_W'(1);
                                r_dac  <= MSB_CODE;
                                r_bit  <= BIT_TOP;
                            end
                        end
                    end
                end
                DONE: begin
                    r_result    <= WIDTH'(w_avg_res);
                    r_result_ch <= r_ch;
                    r_valid     <= 1'b1;
                    r_acc       <= '0;
                    r_conv      <= '0;
                    r_settle    <= '0;
                    r_bit       <= BIT_TOP;
                    if (!w_last_ch) begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_dac   <= MSB_CODE;
                        r_state <= TRIAL;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_ch        <= '0;
                        if (continuous) begin
                            r_avg   <= avg_en && (AVG_LOG2 != 0);
                            r_dac   <= MSB_CODE;
                            r_state <= TRIAL;
                        end else begin
                            r_dac   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dac_out      = r_dac;
    assign ch_sel       = r_ch;
    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = r_valid;
    assign scan_done    = r_scan_done;
    assign busy         = r_busy;
endmodule

// File: tb/tb_sar_scan_adc.sv
// Scoreboard bench for sar_scan_adc: a comparator model follows a programmed Vin,
// expected results are queued at stimulus time and checked by a separate monitor.
module tb_sar_scan_adc;
    localparam int WIDTH         = 8;
    localparam int SETTLE_CYCLES = 4;
    localparam int NUM_CH        = 2;
    localparam int AVG_LOG2      = 1;
    localparam int BUDGET        = 2000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             avg_en = 1'b0;
    logic             comp_in = 1'b0;
    logic [WIDTH-1:0] dac_out;
    logic [0:0]       ch_sel;
    logic [WIDTH-1:0] result;
    logic [0:0]       result_ch;
    logic             result_valid;
    logic             scan_done;
    logic             busy;

    typedef struct {
        logic [7:0] res;
        logic       ch;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] vin_q[$];
    logic [7:0] vin = 8'h00;
    logic [7:0] prev_dac = 8'h00;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         n_seen = 0;
    int         n_expected = 0;

    sar_scan_adc #(
        .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES), .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .avg_en(avg_en), .comp_in(comp_in), .dac_out(dac_out), .ch_sel(ch_sel),
        .result(result), .result_ch(result_ch), .result_valid(result_valid),
        .scan_done(scan_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Comparator model: a new Vin is taken from the queue whenever a conversion begins.
    always @(negedge clk) begin
        if (dac_out == 8'h80 && prev_dac != 8'h80 && vin_q.size() > 0)
            vin = vin_q.pop_front();
        comp_in  = (vin >= dac_out);
        prev_dac = dac_out;
    end

    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%0h ch %0d expected no result", result, result_ch);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("result_ch", 32'(result_ch), 32'(e.ch));
                check("scan_done", 32'(scan_done), 32'(e.done));
                if (e.cyc != 0) check("latency_edge", 32'(cyc), 32'(e.cyc));
            end
            n_seen++;
        end else if (scan_done) begin
            checks++;
            errors++;
            $display("FAIL lone_scan_done: got scan_done 1 expected 0 without result_valid");
        end
    end

    task automatic expect_result(input logic [7:0] res, input logic ch, input logic done, input int at);
        exp_t e;
        e.res = res; e.ch = ch; e.done = done; e.cyc = at;
        exp_q.push_back(e);
        n_expected++;
    endtask

    task automatic do_start(input logic avg, output int k);
        @(negedge clk);
        start  = 1'b1;
        avg_en = avg;
        k      = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        avg_en = 1'b0;
    endtask

    task automatic wait_results;
        int n;
        n = 0;
        while (n_seen < n_expected && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check("results_before_timeout", 32'(n_seen), 32'(n_expected));
    endtask

    initial begin
        int         k;
        logic [7:0] m;

        repeat (3) @(negedge clk);
        check("reset_outputs", {dac_out, 7'(ch_sel), result, 7'(result_ch), 5'(result_valid), 4'(scan_done), 4'(busy)}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single conversion per channel, Vin 0xDA gives trial decisions 1,1,0,1,1,0,1,0.
        vin_q.push_back(8'hDA);
        expect_result(8'hDA, 1'b0, 1'b0, 0);
        expect_result(8'hDA, 1'b1, 1'b1, 0);
        do_start(1'b0, k);
        exp_q[0].cyc = k + 33;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_results();
        @(negedge clk);
        check("busy_after_sweep", 32'(busy), 32'h0);
        repeat (80) @(negedge clk);
        check("no_extra_sweep_busy", 32'(busy), 32'h0);

        // Full-scale then zero input, with the DAC trial sequence observed.
        vin_q.push_back(8'hFF);
        expect_result(8'hFF, 1'b0, 1'b0, 0);
        expect_result(8'hFF, 1'b1, 1'b1, 0);
        do_start(1'b0, k);
        for (int b = 0; b < 8; b++) begin
            if (b != 0) repeat (4) @(negedge clk);
            m = 8'hFF;
            m = m << (7 - b);
            check("dac_trial_code", 32'(dac_out), 32'(m));
        end
        wait_results();
        vin_q.push_back(8'h00);
        expect_result(8'h00, 1'b0, 1'b0, 0);
        expect_result(8'h00, 1'b1, 1'b1, 0);
        do_start(1'b0, k);
        wait_results();
        @(negedge clk);
        check("dac_idle_zero", 32'(dac_out), 32'h0);

        // Averaging: (0xDA+0xDB)>>1 = 0xDA on ch0, (0x10+0x13)>>1 = 0x11 on ch1.
        vin_q.push_back(8'hDA);
        vin_q.push_back(8'hDB);
        vin_q.push_back(8'h10);
        vin_q.push_back(8'h13);
        expect_result(8'hDA, 1'b0, 1'b0, 0);
        expect_result(8'h11, 1'b1, 1'b1, 0);
        do_start(1'b1, k);
        exp_q[0].cyc = k + 65;
        wait_results();

        // Continuous scanning, dropped during the third sweep.
        vin_q.push_back(8'h5A);
        for (int i = 0; i < 6; i++) expect_result(8'h5A, 1'(i % 2), 1'(i % 2), 0);
        continuous = 1'b1;
        do_start(1'b0, k);
        exp_q[0].cyc = k + 33;
        repeat (149) @(negedge clk);
        check("busy_mid_third_sweep", 32'(busy), 32'h1);
        continuous = 1'b0;
        wait_results();
        @(negedge clk);
        check("busy_after_continuous", 32'(busy), 32'h0);

        // Reset after the fourth bit decision: abort with no result.
        vin_q.push_back(8'h33);
        do_start(1'b0, k);
        repeat (16) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("abort_outputs", {dac_out, 7'(ch_sel), result, 7'(result_ch), 5'(result_valid), 4'(scan_done), 4'(busy)}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_after_abort", {23'(dac_out), 9'(busy)}, 32'h0);
        check("no_pending_results", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
